// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC holder and single-outstanding instruction fetcher
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_next_i,
  input  logic             advance,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      pc_current,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             req_valid_q, req_valid_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state logic; all outputs are registered and derived from the next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_REQ: begin
        // valid is only presented once registered, so the handshake uses the flop
        if (req_valid_q && imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) begin
          pc_d    = pc_next_i;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (pc_next_i[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
    req_valid_d   = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
    fault_d       = (state_d == S_FAULT);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign pc_current     = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign fetch_fault    = fault_q;
  assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_next_i = 32'h0;
  logic        advance = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] pc_current;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic [31:0] retired_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int n_accept = 0;

  pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next_i(pc_next_i), .advance(advance),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc_current(pc_current), .instr(instr),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks whether we are asking, waiting, holding or faulted
  logic [31:0] m_pc = 32'h0, m_instr = 32'h13, m_cnt = 32'h0;
  logic        m_iv = 1'b0, m_fault = 1'b0, m_req = 1'b0;
  bit          m_waiting = 0, m_holding = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h13; m_cnt = 32'h0;
      m_iv = 0; m_fault = 0; m_req = 0; m_waiting = 0; m_holding = 0;
    end else if (m_fault) begin
      // halted until reset
    end else if (m_holding) begin
      if (advance) begin
        m_cnt = m_cnt + 1;
        m_pc = pc_next_i;
        m_holding = 0;
        m_iv = 0;
        if (pc_next_i % 4 != 0) m_fault = 1;
        else m_req = 1;
      end
    end else if (m_waiting) begin
      if (imem_rsp_valid) begin
        m_instr = imem_rsp_data;
        m_waiting = 0;
        m_holding = 1;
        m_iv = 1;
      end
    end else begin
      if (m_req && imem_req_ready) begin
        m_req = 0;
        m_waiting = 1;
      end else begin
        m_req = 1;
      end
    end
  end

  // Count handshakes seen on the request port
  always @(posedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) n_accept++;
  end

  // Compare every output with the model away from the active edge
  always @(negedge clk) begin
    check("m_req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
    check("m_req_addr", imem_req_addr, m_pc);
    check("m_pc", pc_current, m_pc);
    check("m_instr", instr, m_instr);
    check("m_instr_valid", {31'b0, instr_valid}, {31'b0, m_iv});
    check("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    check("m_cnt", retired_cnt, m_cnt);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int stall, output logic [31:0] addr);
    int n = 0;
    imem_req_ready = 0;
    while (!imem_req_valid && n < 20) begin step(); n++; end
    if (!imem_req_valid) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: got req_valid=0 expected 1 within 20 cycles");
      addr = 32'hx;
      return;
    end
    addr = imem_req_addr;
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", {31'b0, imem_req_valid}, 32'h1);
      check("stall_addr", imem_req_addr, addr);
    end
    imem_req_ready = 1; step(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = data; step(); imem_rsp_valid = 0;
  endtask

  task automatic do_advance(input logic [31:0] nxt);
    advance = 1; pc_next_i = nxt; step(); advance = 0;
  endtask

  logic [31:0] a;

  initial begin
    repeat (2) step();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_pc", pc_current, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_iv", {31'b0, instr_valid}, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
    check("rst_cnt", retired_cnt, 32'h0);
    rst_n = 1;

    // first fetch
    do_fetch(32'h0050_0093, 0, a);
    check("t1_addr", a, 32'h0);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_iv", {31'b0, instr_valid}, 32'h1);
    check("t1_pc", pc_current, 32'h0);

    // sequential flow
    do_advance(32'h4);
    check("t2_gap1", {31'b0, instr_valid}, 32'h0);
    do_fetch(32'h0040_0113, 0, a);
    check("t2_addr4", a, 32'h4);
    check("t2_instr4", instr, 32'h0040_0113);
    do_advance(32'h8);
    check("t2_gap2", {31'b0, instr_valid}, 32'h0);
    do_fetch(32'h0030_0193, 0, a);
    check("t2_addr8", a, 32'h8);
    check("t2_cnt", retired_cnt, 32'h2);

    // backpressure
    do_advance(32'h4);
    do_fetch(32'h0020_0213, 5, a);
    check("t3_addr", a, 32'h4);
    check("t3_instr", instr, 32'h0020_0213);
    check("t3_accepts", n_accept, 32'h4);

    // misaligned next PC
    do_advance(32'h0000_0102);
    check("t4_fault", {31'b0, fetch_fault}, 32'h1);
    check("t4_pc", pc_current, 32'h102);
    check("t4_cnt", retired_cnt, 32'h4);
    advance = 1; pc_next_i = 32'h200; imem_req_ready = 1;
    repeat (4) step();
    advance = 0; imem_req_ready = 0;
    check("t4_pc_held", pc_current, 32'h102);
    check("t4_cnt_held", retired_cnt, 32'h4);
    check("t4_no_req", {31'b0, imem_req_valid}, 32'h0);
    check("t4_accepts", n_accept, 32'h4);

    // async reset out of fault, then spurious inputs while requesting
    rst_n = 0; #1;
    check("t5_rst_fault", {31'b0, fetch_fault}, 32'h0);
    check("t5_rst_pc", pc_current, 32'h0);
    step(); rst_n = 1; step();
    advance = 1; pc_next_i = 32'h40; imem_rsp_valid = 1; imem_rsp_data = 32'hdead_beef;
    repeat (3) step();
    advance = 0; imem_rsp_valid = 0;
    check("t5_spur_pc", pc_current, 32'h0);
    check("t5_spur_cnt", retired_cnt, 32'h0);
    check("t5_spur_instr", instr, 32'h0000_0013);
    check("t5_spur_req", {31'b0, imem_req_valid}, 32'h1);
    imem_req_ready = 1; step(); imem_req_ready = 0;
    rst_n = 0; #1;
    check("t5_wait_rst_req", {31'b0, imem_req_valid}, 32'h0);
    check("t5_wait_rst_iv", {31'b0, instr_valid}, 32'h0);
    check("t5_wait_rst_instr", instr, 32'h0000_0013);
    step(); rst_n = 1;
    do_fetch(32'h0010_0073, 0, a);
    check("t5_refetch_addr", a, 32'h0);
    check("t5_refetch_instr", instr, 32'h0010_0073);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
